// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity frame receiver: FSM encoding,
// default frame width and the saturating error-counter helper.
package parity_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int ERR_CNT_W      = 8;

    typedef enum logic [1:0] {
        RX_DATA  = 2'd0,
        RX_PAR   = 2'd1,
        OUT_HOLD = 2'd2
    } rx_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR used for the running-parity update.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: DATA_W data bits LSB first followed by one parity
// bit; presents the assembled word and a parity verdict with a ready/valid handshake.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_par;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     r_data_out;
    logic                  r_parity_err;
    logic                  r_out_valid;
    logic [ERR_CNT_W-1:0]  r_err_count;

    logic                  w_bit_ready;
    logic                  w_accept;
    logic                  w_last_data;
    logic                  w_par_nxt;
    logic                  w_frame_err;

    // Ready depends on state alone so upstream never sees a combinational loop.
    assign w_bit_ready = (r_state != OUT_HOLD);
    assign w_accept    = bit_valid & w_bit_ready;
    assign w_last_data = (r_bit_cnt == LAST_IDX);
    assign w_frame_err = w_par_nxt ^ ODD_PARITY;

    xor_gate u_par_xor (
        .a (r_par),
        .b (bit_in),
        .y (w_par_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_DATA:  if (w_accept && w_last_data) w_state_nxt = RX_PAR;
            RX_PAR:   if (w_accept)                w_state_nxt = OUT_HOLD;
            OUT_HOLD: if (out_ready)               w_state_nxt = RX_DATA;
            default:                               w_state_nxt = RX_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_par        <= 1'b0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_parity_err <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                RX_DATA: begin
                    if (w_accept) begin
                        r_shift[r_bit_cnt] <= bit_in;
                        r_par              <= w_par_nxt;
                        r_bit_cnt          <= w_last_data ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (w_accept) begin
                        r_data_out   <= r_shift;
                        r_parity_err <= w_frame_err;
                        r_out_valid  <= 1'b1;
                        if (w_frame_err) r_err_count <= sat_inc(r_err_count);
                    end
                end
                OUT_HOLD: begin
                    // Result regs keep their value after the handshake; only
                    // the frame accumulators restart.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_par       <= 1'b0;
                        r_shift     <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready  = w_bit_ready;
    assign data_out   = r_data_out;
    assign parity_err = r_parity_err;
    assign out_valid  = r_out_valid;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench: an even-parity and an odd-parity receiver share one stimulus stream.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       e_bit_ready, e_parity_err, e_out_valid;
    logic [7:0] e_data_out, e_err_count;
    logic       o_bit_ready, o_parity_err, o_out_valid;
    logic [7:0] o_data_out, o_err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_e   = 0;
    int cnt_o   = 0;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(e_bit_ready), .data_out(e_data_out), .parity_err(e_parity_err),
        .out_valid(e_out_valid), .out_ready(out_ready), .err_count(e_err_count)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(o_bit_ready), .data_out(o_data_out), .parity_err(o_parity_err),
        .out_valid(o_out_valid), .out_ready(out_ready), .err_count(o_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    // Expected verdicts come from the frame contents: even-mode error is the
    // XOR of all nine bits, odd-mode error is its complement.
    task automatic check_result(input string tag, input logic [7:0] d, input logic p);
        logic e_err, o_err;
        e_err = (^d) ^ p;
        o_err = ~e_err;
        if (e_err && cnt_e < 255) cnt_e++;
        if (o_err && cnt_o < 255) cnt_o++;
        chk({tag, "_e_valid"}, {31'd0, e_out_valid}, 32'd1);
        chk({tag, "_o_valid"}, {31'd0, o_out_valid}, 32'd1);
        chk({tag, "_e_data"},  {24'd0, e_data_out},  {24'd0, d});
        chk({tag, "_o_data"},  {24'd0, o_data_out},  {24'd0, d});
        chk({tag, "_e_err"},   {31'd0, e_parity_err}, {31'd0, e_err});
        chk({tag, "_o_err"},   {31'd0, o_parity_err}, {31'd0, o_err});
        chk({tag, "_e_cnt"},   {24'd0, e_err_count}, cnt_e);
        chk({tag, "_o_cnt"},   {24'd0, o_err_count}, cnt_o);
        chk({tag, "_rdy_lo"},  {31'd0, e_bit_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, {31'd0, e_out_valid}, 32'd0);
        chk({tag, "_hs_rdy"},   {31'd0, e_bit_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] held_d;
        logic       held_e;

        // Reset state
        #12;
        chk("rst_data",  {24'd0, e_data_out},  32'd0);
        chk("rst_err",   {31'd0, e_parity_err}, 32'd0);
        chk("rst_valid", {31'd0, e_out_valid}, 32'd0);
        chk("rst_cnt",   {24'd0, e_err_count}, 32'd0);
        chk("rst_rdy",   {31'd0, e_bit_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // 0xA5 good even parity; result exactly one cycle after the parity bit
        send_data(8'hA5);
        chk("a5_pre_valid", {31'd0, e_out_valid}, 32'd0);
        chk("a5_pre_rdy",   {31'd0, e_bit_ready}, 32'd1);
        send_bit(1'b0);
        chk("a5_data_hand", {24'd0, e_data_out}, 32'h0000_00A5);
        chk("a5_err_hand",  {31'd0, e_parity_err}, 32'd0);
        check_result("a5p0", 8'hA5, 1'b0);
        handshake("a5p0");
        chk("a5_hold_data", {24'd0, e_data_out}, 32'h0000_00A5);

        // Same data, bad parity
        send_data(8'hA5);
        send_bit(1'b1);
        chk("a5p1_err_hand", {31'd0, e_parity_err}, 32'd1);
        chk("a5p1_cnt_hand", {24'd0, e_err_count}, 32'd1);
        check_result("a5p1", 8'hA5, 1'b1);
        handshake("a5p1");

        // Consumer stall: result frozen, presented bits dropped
        send_data(8'hA5);
        send_bit(1'b0);
        check_result("stall", 8'hA5, 1'b0);
        held_d = e_data_out;
        held_e = e_parity_err;
        for (int c = 0; c < 5; c++) begin
            bit_valid = 1'b1;
            bit_in    = c[0];
            step();
            chk("stall_valid", {31'd0, e_out_valid}, 32'd1);
            chk("stall_data",  {24'd0, e_data_out}, {24'd0, held_d});
            chk("stall_err",   {31'd0, e_parity_err}, {31'd0, held_e});
            chk("stall_rdy",   {31'd0, e_bit_ready}, 32'd0);
        end
        bit_valid = 1'b0;
        handshake("stall");
        send_data(8'h5A);
        send_bit(1'b0);
        check_result("post_stall", 8'h5A, 1'b0);
        handshake("post_stall");

        // 0x3C with random idle gaps carrying garbage on bit_in
        for (int i = 0; i < 9; i++) begin
            automatic logic [8:0] fr = {1'b0, 8'h3C};
            automatic int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bit_in = 1'($urandom);
                step();
            end
            send_bit(fr[i]);
        end
        check_result("gaps3c", 8'h3C, 1'b0);
        chk("gaps3c_data", {24'd0, e_data_out}, 32'h0000_003C);
        handshake("gaps3c");

        // 300 bad frames: even-mode counter saturates at 255
        for (int f = 0; f < 300; f++) begin
            send_data(8'hA5);
            send_bit(1'b1);
            if (1'b1 && cnt_e < 255) cnt_e++;
            chk("sat_cnt", {24'd0, e_err_count}, cnt_e);
            handshake("sat");
        end
        chk("sat_255", {24'd0, e_err_count}, 32'd255);
        chk("sat_odd_cnt", {24'd0, o_err_count}, cnt_o);

        // Asynchronous reset mid-frame after three data bits
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data",  {24'd0, e_data_out},  32'd0);
        chk("arst_err",   {31'd0, e_parity_err}, 32'd0);
        chk("arst_valid", {31'd0, e_out_valid}, 32'd0);
        chk("arst_cnt",   {24'd0, e_err_count}, 32'd0);
        chk("arst_ocnt",  {24'd0, o_err_count}, 32'd0);
        chk("arst_rdy",   {31'd0, e_bit_ready}, 32'd1);
        cnt_e = 0;
        cnt_o = 0;
        #2 rst_n = 1'b1;
        step();
        send_data(8'hFF);
        send_bit(1'b0);
        check_result("ff", 8'hFF, 1'b0);
        handshake("ff");

        // Odd parity on 0x00
        send_data(8'h00);
        send_bit(1'b1);
        chk("odd00p1_err", {31'd0, o_parity_err}, 32'd0);
        check_result("z_p1", 8'h00, 1'b1);
        handshake("z_p1");
        send_data(8'h00);
        send_bit(1'b0);
        chk("odd00p0_err", {31'd0, o_parity_err}, 32'd1);
        check_result("z_p0", 8'h00, 1'b0);
        handshake("z_p0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
